uart_tx_stream: RTL and testbench
=================================

Name: uart_tx_stream

Overview:
Parametrised UART transmitter, next generation of the team's fixed 8N1 transmitter. It adds a valid/ready input stream buffered by a small FIFO, plus parametrised character width and FIFO depth. Parity (none/even/odd) and 1 or 2 stop bits are selected at run time. It sits between a byte-producing controller and the board-level serial TX pin.

Parameters:
CLOCK_FREQ, 12_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bits/s
DATA_BITS, 8, character width; legal range 5..9
FIFO_DEPTH, 4, buffered characters; power of two, >= 2
CLKS_PER_BIT, CLOCK_FREQ/BAUD_RATE, derived, not overridden; must be >= 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
s_data  input  DATA_BITS  character to transmit
s_valid  input  1  s_data valid
s_ready  output  1  FIFO can accept; high = not full
parity_en  input  1  1 = append parity bit
parity_odd  input  1  0 = even parity, 1 = odd parity (ignored when parity_en = 0)
stop2  input  1  0 = one stop bit, 1 = two stop bits
tx  output  1  serial line, idle high
busy  output  1  high while the FSM is not IDLE or the FIFO is non-empty
fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, immediate): tx = 1, busy = 0, fifo_level = 0, s_ready = 1, FSM = IDLE, FIFO pointers cleared, baud counter = 0. Reset mid-frame aborts the frame; tx returns high at once; buffered characters are discarded.
- Handshake: a character is accepted on a rising edge with s_valid && s_ready. s_ready = (fifo_level != FIFO_DEPTH), computed from registered state. No combinational path from s_valid to s_ready.
- FIFO: push and pop on the same edge are permitted when non-empty and not full; level is unchanged. A push while full cannot occur (s_ready = 0). Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx = 1. If FIFO non-empty, pop the head into the shift register, latch parity_en/parity_odd/stop2 into frame config, and go to START. Config changes mid-frame have no effect until the next frame.
  - START: tx = 0 for CLKS_PER_BIT clocks, then go to DATA.
  - DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT clocks. After the last bit, go to PARITY if parity_en was latched, else STOP.
  - PARITY: tx = XOR of all data bits, inverted when parity_odd; held CLKS_PER_BIT clocks.
  - STOP: tx = 1 for CLKS_PER_BIT clocks (1 stop bit) or 2*CLKS_PER_BIT clocks (stop2). Then go to IDLE.
- tx is a registered output; every bit period is exactly CLKS_PER_BIT clocks with no jitter.
- Latency: with the FSM in IDLE and the FIFO empty, a character accepted at edge N is popped at edge N+1. tx falls at edge N+2.
- Back-to-back: IDLE lasts exactly one clock between frames when the FIFO is non-empty. Inter-frame gap = stop length + 1 clock.
- Frame length in clocks = CLKS_PER_BIT * (1 + DATA_BITS + parity_en + 1 + stop2).
- Baud counter: counts 0..CLKS_PER_BIT-1 and restarts on every bit boundary and on frame start. Width = clog2(CLKS_PER_BIT)+1.
- busy is registered, falls the clock after the final stop period ends with the FIFO empty.

Test Plan:
1. CLOCK_FREQ=160, BAUD_RATE=10 (16 clks/bit), DATA_BITS=8, no parity, 1 stop, push 0xA5 -> tx low on 2nd edge after accept; sampled LSB-first sequence 0,1,0,1,0,0,1,0,1,1; frame 160 clocks; busy then drops.
2. Same setup, parity_en=1, parity_odd=0, push 0x07 -> parity bit 1. With parity_odd=1 -> parity bit 0. stop2=1 -> stop high 32 clocks; frame 192 clocks.
3. FIFO_DEPTH=4, s_valid held high with 0x11,0x22,0x33,0x44,0x55,0x66 -> s_ready low when fifo_level=4 (one character already popped into the shift register). All six characters are sent in order with a 17-clock stop+idle gap and no loss or duplication.
4. Change parity_en/stop2 in the middle of frame 1 -> frame 1 uses its latched config; frame 2 uses the new config.
5. Assert reset during the DATA state of a 0x00 frame, with 2 characters queued -> tx=1 immediately; fifo_level=0, busy=0; nothing is transmitted after release until a new push.
6. DATA_BITS=5 and DATA_BITS=9, push all-ones -> exactly 5 or 9 data bits at 1, followed by the stop bit(s); even parity gives 1 for 5 bits and 1 for 9 bits.

Source files
------------

// File: rtl/uart_tx_stream.sv
// UART transmitter with a valid/ready input stream buffered by a small FIFO.
// Character width, FIFO depth and line rate are parameters. Parity
// (none/even/odd) and one or two stop bits are latched per frame.
module uart_tx_stream #(
    parameter int CLOCK_FREQ = 12_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        parity_en,
    input  logic                        parity_odd,
    input  logic                        stop2,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int LVL_W        = PTR_W + 1;
    localparam int BIT_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] FIFO_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shreg;
    logic [CNT_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 par_bit;
    logic                 cfg_parity;
    logic                 cfg_stop2;
    logic                 stop_second;
    logic                 push;
    logic                 pop;
    logic                 bit_done;

    assign s_ready  = (fifo_level != FIFO_FULL);
    assign push     = s_valid && s_ready;
    assign pop      = (state == IDLE) && (fifo_level != '0);
    assign head     = mem[rd_ptr];
    assign bit_done = (baud_cnt == LAST_TICK);

    // FIFO storage: written on every accepted character, no reset needed
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_data;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves level unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_level <= fifo_level + 1'b1;
            else if (pop && !push)
                fifo_level <= fifo_level - 1'b1;
        end
    end

    // Frame sequencer. tx is registered from the current state, so the line
    // trails the state by one clock; every state lasts whole bit periods, so
    // bit lengths on the wire stay exact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx          <= 1'b1;
            busy        <= 1'b0;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            cfg_parity  <= 1'b0;
            cfg_stop2   <= 1'b0;
            stop_second <= 1'b0;
        end else begin
            busy <= (state != IDLE) || (fifo_level != '0);
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shreg       <= head;
                        par_bit     <= (^head) ^ parity_odd;
                        cfg_parity  <= parity_en;
                        cfg_stop2   <= stop2;
                        bit_idx     <= '0;
                        stop_second <= 1'b0;
                        state       <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx <= shreg[0];
                    if (bit_done) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_idx == BIT_LAST)
                            state <= cfg_parity ? PARITY : STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    tx <= par_bit;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (cfg_stop2 && !stop_second)
                            stop_second <= 1'b1;
                        else
                            state <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Self-checking bench for uart_tx_stream: directed and randomized frames
// compared against a bit-list model of the serial frame.
module tb_uart_tx_stream;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       stop2 = 1'b0;

    logic [7:0] s_data8 = '0;
    logic       s_valid8 = 1'b0;
    logic       s_ready8, tx8, busy8;
    logic [2:0] level8;

    logic [4:0] s_data5 = '0;
    logic       s_valid5 = 1'b0;
    logic       s_ready5, tx5, busy5;
    logic [2:0] level5;

    logic [8:0] s_data9 = '0;
    logic       s_valid9 = 1'b0;
    logic       s_ready9, tx9, busy9;
    logic [2:0] level9;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    bit         frame_bits[$];

    always #5 clk = ~clk;

    uart_tx_stream #(.CLOCK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(8), .FIFO_DEPTH(4)) dut8 (
        .clk(clk), .reset(reset), .s_data(s_data8), .s_valid(s_valid8), .s_ready(s_ready8),
        .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
        .tx(tx8), .busy(busy8), .fifo_level(level8)
    );

    uart_tx_stream #(.CLOCK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(5), .FIFO_DEPTH(4)) dut5 (
        .clk(clk), .reset(reset), .s_data(s_data5), .s_valid(s_valid5), .s_ready(s_ready5),
        .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
        .tx(tx5), .busy(busy5), .fifo_level(level5)
    );

    uart_tx_stream #(.CLOCK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(9), .FIFO_DEPTH(4)) dut9 (
        .clk(clk), .reset(reset), .s_data(s_data9), .s_valid(s_valid9), .s_ready(s_ready9),
        .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
        .tx(tx9), .busy(busy9), .fifo_level(level9)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic tx_of(input int sel);
        case (sel)
            1:       return tx5;
            2:       return tx9;
            default: return tx8;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            1:       return busy5;
            2:       return busy9;
            default: return busy8;
        endcase
    endfunction

    function automatic logic ready_of(input int sel);
        case (sel)
            1:       return s_ready5;
            2:       return s_ready9;
            default: return s_ready8;
        endcase
    endfunction

    function automatic int nbits_of(input int sel);
        case (sel)
            1:       return 5;
            2:       return 9;
            default: return 8;
        endcase
    endfunction

    // Expected line levels, one entry per bit period
    function automatic void build_frame(input logic [8:0] d, input int nbits,
                                        input bit pe, input bit po, input bit s2);
        int ones;
        ones = 0;
        frame_bits.delete();
        frame_bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            frame_bits.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (pe)
            frame_bits.push_back(((ones % 2) == 1) ^ po);
        frame_bits.push_back(1'b1);
        if (s2)
            frame_bits.push_back(1'b1);
    endfunction

    // Offer one character; returns on the falling edge after it was accepted
    task automatic push(input int sel, input logic [8:0] d);
        int   w;
        logic rdy;
        w   = 0;
        rdy = 1'b0;
        case (sel)
            1:       begin s_data5 = d[4:0]; s_valid5 = 1'b1; end
            2:       begin s_data9 = d;      s_valid9 = 1'b1; end
            default: begin s_data8 = d[7:0]; s_valid8 = 1'b1; end
        endcase
        while (!rdy && w < 400) begin
            rdy = ready_of(sel);
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        s_valid5 = 1'b0;
        s_valid8 = 1'b0;
        s_valid9 = 1'b0;
        if (rdy)
            exp_q.push_back(d);
        check("push_accept", rdy, 1);
    endtask

    // Wait for a start bit, then compare every clock of the frame to the model
    task automatic check_frame(input int sel, input int budget, input int exp_wait,
                               input bit pe, input bit po, input bit s2, input bit idle_after);
        int         n;
        logic [8:0] d;
        logic       seen;
        n = 0;
        while (tx_of(sel) !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (tx_of(sel) !== 1'b0) begin
            check("start_timeout", tx_of(sel), 0);
            return;
        end
        if (exp_wait >= 0)
            check("start_latency", n, exp_wait);
        if (exp_q.size() == 0) begin
            check("unexpected_frame", exp_q.size(), 1);
            return;
        end
        d = exp_q.pop_front();
        build_frame(d, nbits_of(sel), pe, po, s2);
        check("busy_in_frame", busy_of(sel), 1);
        foreach (frame_bits[b]) begin
            seen = frame_bits[b];
            for (int c = 0; c < CPB; c++) begin
                if (tx_of(sel) !== frame_bits[b])
                    seen = tx_of(sel);
                @(negedge clk);
            end
            check($sformatf("frame_%0h_bit%0d", d, b), seen, frame_bits[b]);
        end
        if (idle_after) begin
            check("tx_idle_after", tx_of(sel), 1);
            check("busy_after", busy_of(sel), 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq [6];
        logic [8:0] rd;
        bit         pe, po, s2;
        int         n, bad, w;
        logic       rdy;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx8, 1);
        check("rst_busy", busy8, 0);
        check("rst_level", level8, 0);
        check("rst_ready", s_ready8, 1);
        reset = 1'b0;
        @(negedge clk);

        // Plain 8N1 frame, with first-character latency
        push(0, 9'h0A5);
        check_frame(0, 10, 2, 1'b0, 1'b0, 1'b0, 1'b1);

        // Parity and two stop bits
        parity_en = 1'b1; parity_odd = 1'b0;
        push(0, 9'h007);
        check_frame(0, 10, 2, 1'b1, 1'b0, 1'b0, 1'b1);
        parity_odd = 1'b1;
        push(0, 9'h007);
        check_frame(0, 10, 2, 1'b1, 1'b1, 1'b0, 1'b1);
        parity_odd = 1'b0; stop2 = 1'b1;
        push(0, 9'h007);
        check_frame(0, 10, 2, 1'b1, 1'b0, 1'b1, 1'b1);

        // Stream with s_valid held: FIFO fills, frames back-to-back
        parity_en = 1'b0; stop2 = 1'b0;
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        fork
            begin
                s_valid8 = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    s_data8 = seq[i];
                    rdy = 1'b0;
                    w = 0;
                    while (!rdy && w < 400) begin
                        rdy = s_ready8;
                        @(posedge clk);
                        @(negedge clk);
                        w++;
                    end
                    if (rdy)
                        exp_q.push_back({1'b0, seq[i]});
                    check("stream_accept", rdy, 1);
                    if (i == 4) begin
                        check("stream_level_full", level8, 4);
                        check("stream_ready_low", s_ready8, 0);
                    end
                end
                s_valid8 = 1'b0;
            end
            begin
                check_frame(0, 20, -1, 1'b0, 1'b0, 1'b0, 1'b0);
                for (int k = 1; k < 6; k++)
                    check_frame(0, 3, 1, 1'b0, 1'b0, 1'b0, k == 5);
            end
        join
        check("stream_leftover", exp_q.size(), 0);

        // Configuration change during frame 1 only affects frame 2
        push(0, 9'h03C);
        push(0, 9'h0C3);
        fork
            check_frame(0, 5, 1, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                repeat (60) @(negedge clk);
                parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b1;
            end
        join
        check_frame(0, 3, 1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Reset during DATA with two characters queued
        parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        push(0, 9'h000);
        push(0, 9'h055);
        push(0, 9'h066);
        n = 0;
        while (tx8 !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (3 * CPB) @(negedge clk);
        check("pre_reset_tx", tx8, 0);
        check("pre_reset_level", level8, 2);
        reset = 1'b1;
        #1;
        check("mid_rst_tx", tx8, 1);
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_level", level8, 0);
        check("mid_rst_ready", s_ready8, 1);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx8 !== 1'b1 || busy8 !== 1'b0 || level8 !== 3'd0)
                bad++;
        end
        check("quiet_after_reset", bad, 0);
        push(0, 9'h096);
        check_frame(0, 10, 2, 1'b0, 1'b0, 1'b0, 1'b1);

        // 5-bit and 9-bit characters, all ones, even parity
        parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b0;
        push(1, 9'h01F);
        check_frame(1, 10, 2, 1'b1, 1'b0, 1'b0, 1'b1);
        stop2 = 1'b1;
        push(2, 9'h1FF);
        check_frame(2, 10, 2, 1'b1, 1'b0, 1'b1, 1'b1);

        // Randomized characters and configurations
        for (int i = 0; i < 10; i++) begin
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            parity_en = pe; parity_odd = po; stop2 = s2;
            if (i < 7) begin
                rd = 9'($urandom_range(0, 255));
                push(0, rd);
                check_frame(0, 10, 2, pe, po, s2, 1'b1);
            end else begin
                rd = 9'($urandom_range(0, 511));
                push(2, rd);
                check_frame(2, 10, 2, pe, po, s2, 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
